// File: rtl/ram_arbiter.sv
// Two-port round-robin / fixed-priority sequencer in front of a single-port RAM with negedge write.
// Optional atomic ownership via RAM_ARBITER_LOCK_EN adds the p0_lock/p1_lock inputs.
module ram_arbiter #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 16,
  parameter int ROUND_ROBIN = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  p0_req,
  input  logic                  p0_we,
  input  logic [ADDR_WIDTH-1:0] p0_addr,
  input  logic [DATA_WIDTH-1:0] p0_wdata,
  output logic                  p0_ack,
  input  logic                  p1_req,
  input  logic                  p1_we,
  input  logic [ADDR_WIDTH-1:0] p1_addr,
  input  logic [DATA_WIDTH-1:0] p1_wdata,
  output logic                  p1_ack,
`ifdef RAM_ARBITER_LOCK_EN
  input  logic                  p0_lock,
  input  logic                  p1_lock,
`endif
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0] ram_in,
  output logic                  ram_is_write,
  input  logic [DATA_WIDTH-1:0] ram_out,
  output logic                  busy,
  output logic                  grant
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t                  state_q;
  logic                    grant_q;
  logic                    last_grant_q;
  logic                    we_q;
  logic                    p0_ack_q;
  logic                    p1_ack_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH-1:0]   rdata_q;

  logic                    any_req_d;
  logic                    winner_d;
  logic                    owned_d;

`ifdef RAM_ARBITER_LOCK_EN
  logic owner_valid_q;
  logic owner_q;
  logic [1:0] lock_vec;

  assign lock_vec = {p1_lock, p0_lock};
  // Ownership is already considered released at an IDLE edge where the owner's lock is low.
  assign owned_d  = owner_valid_q & lock_vec[owner_q];
`else
  assign owned_d  = 1'b0;
`endif

  always_comb begin
    any_req_d = p0_req | p1_req;
    if (p0_req && p1_req) begin
      winner_d = (ROUND_ROBIN != 0) ? ~last_grant_q : 1'b0;
    end else begin
      winner_d = p1_req;
    end
`ifdef RAM_ARBITER_LOCK_EN
    if (owned_d) begin
      any_req_d = owner_q ? p1_req : p0_req;
      winner_d  = owner_q;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      we_q         <= 1'b0;
      p0_ack_q     <= 1'b0;
      p1_ack_q     <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
`ifdef RAM_ARBITER_LOCK_EN
      owner_valid_q <= 1'b0;
      owner_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          p0_ack_q <= 1'b0;
          p1_ack_q <= 1'b0;
`ifdef RAM_ARBITER_LOCK_EN
          owner_valid_q <= owned_d;
`endif
          if (any_req_d) begin
            grant_q <= winner_d;
            addr_q  <= winner_d ? p1_addr  : p0_addr;
            wdata_q <= winner_d ? p1_wdata : p0_wdata;
            we_q    <= winner_d ? p1_we    : p0_we;
            if (!owned_d) begin
              last_grant_q <= winner_d;
            end
            state_q <= ACCESS;
          end else begin
            we_q <= 1'b0;
          end
        end
        ACCESS: begin
          // For writes the combinational read already reflects the negedge commit.
          rdata_q  <= ram_out;
          p0_ack_q <= ~grant_q;
          p1_ack_q <= grant_q;
          we_q     <= 1'b0;
          state_q  <= DONE;
        end
        DONE: begin
          p0_ack_q <= 1'b0;
          p1_ack_q <= 1'b0;
`ifdef RAM_ARBITER_LOCK_EN
          owner_valid_q <= lock_vec[grant_q];
          owner_q       <= grant_q;
`endif
          state_q  <= IDLE;
        end
        default: begin
          p0_ack_q <= 1'b0;
          p1_ack_q <= 1'b0;
          we_q     <= 1'b0;
          state_q  <= IDLE;
        end
      endcase
    end
  end

  assign p0_ack       = p0_ack_q;
  assign p1_ack       = p1_ack_q;
  assign rdata        = rdata_q;
  assign ram_address  = addr_q;
  assign ram_in       = wdata_q;
  assign ram_is_write = we_q;
  assign busy         = (state_q != IDLE);
  assign grant        = grant_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: table of single transactions plus contention, fixed-priority and reset sequences.
module tb_ram_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;

  logic        p0_req = 0, p0_we = 0, p1_req = 0, p1_we = 0;
  logic [15:0] p0_addr = 0, p1_addr = 0;
  logic [31:0] p0_wdata = 0, p1_wdata = 0;
  logic        p0_ack, p1_ack, ram_is_write, busy, grant;
  logic [31:0] rdata, ram_in, ram_out;
  logic [15:0] ram_address;

  logic        f0_req = 0, f1_req = 0;
  logic        fp0_ack, fp1_ack, fram_is_write, fbusy, fgrant;
  logic [31:0] frdata, fram_in, fram_out;
  logic [15:0] fram_address;

  logic [31:0] mem    [0:65535];
  logic [31:0] mem_fp [0:65535];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  always @(negedge clk) if (ram_is_write)  mem[ram_address]     <= ram_in;
  always @(negedge clk) if (fram_is_write) mem_fp[fram_address] <= fram_in;
  assign ram_out  = mem[ram_address];
  assign fram_out = mem_fp[fram_address];

  ram_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .ROUND_ROBIN(1)) u_dut (
    .clk(clk), .reset_n(reset_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_ack(p0_ack),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_ack(p1_ack),
`ifdef RAM_ARBITER_LOCK_EN
    .p0_lock(1'b0), .p1_lock(1'b0),
`endif
    .rdata(rdata), .ram_address(ram_address), .ram_in(ram_in), .ram_is_write(ram_is_write),
    .ram_out(ram_out), .busy(busy), .grant(grant)
  );

  ram_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .ROUND_ROBIN(0)) u_fp (
    .clk(clk), .reset_n(reset_n),
    .p0_req(f0_req), .p0_we(1'b0), .p0_addr(16'h0010), .p0_wdata(32'h0), .p0_ack(fp0_ack),
    .p1_req(f1_req), .p1_we(1'b0), .p1_addr(16'h0020), .p1_wdata(32'h0), .p1_ack(fp1_ack),
`ifdef RAM_ARBITER_LOCK_EN
    .p0_lock(1'b0), .p1_lock(1'b0),
`endif
    .rdata(frdata), .ram_address(fram_address), .ram_in(fram_in), .ram_is_write(fram_is_write),
    .ram_out(fram_out), .busy(fbusy), .grant(fgrant)
  );

  typedef struct {
    logic        p0_req;
    logic        p0_we;
    logic [15:0] p0_addr;
    logic [31:0] p0_wdata;
    logic        p1_req;
    logic        p1_we;
    logic [15:0] p1_addr;
    logic [31:0] p1_wdata;
    logic        exp_grant;
    logic [31:0] exp_rdata;
    logic        exp_we;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int lat;
    int wcnt;
    bit got;
    @(negedge clk);
    p0_req = v.p0_req; p0_we = v.p0_we; p0_addr = v.p0_addr; p0_wdata = v.p0_wdata;
    p1_req = v.p1_req; p1_we = v.p1_we; p1_addr = v.p1_addr; p1_wdata = v.p1_wdata;
    lat = 0; wcnt = 0; got = 0;
    for (int c = 1; c <= 6 && !got; c++) begin
      @(negedge clk);
      if (p0_ack && p1_ack) chk("both_acks", 32'd1, 32'd0);
      if (ram_is_write) wcnt++;
      if (p0_ack || p1_ack) begin
        got = 1;
        lat = c;
      end
    end
    if (!got) begin
      chk("ack_timeout", 32'd0, 32'd1);
    end else begin
      chk("vec_latency", 32'(lat), 32'd2);
      chk("vec_p0_ack", {31'd0, p0_ack}, {31'd0, ~v.exp_grant});
      chk("vec_p1_ack", {31'd0, p1_ack}, {31'd0, v.exp_grant});
      chk("vec_grant", {31'd0, grant}, {31'd0, v.exp_grant});
      chk("vec_rdata", rdata, v.exp_rdata);
      chk("vec_we_cycles", 32'(wcnt), {31'd0, v.exp_we});
    end
    $display("vec %0d: grant=%0d rdata=%h latency=%0d we_cycles=%0d", idx, grant, rdata, lat, wcnt);
    p0_req = 0; p1_req = 0;
  endtask

  initial begin
    int ack_cnt;
    int last_ack_c;
    int fp0_cnt;
    int fp1_cnt;
    logic [31:0] exp_g;
    logic [31:0] exp_d;

    for (int i = 0; i < 65536; i++) begin
      mem[i]    = {16'hC0DE, 16'(i)};
      mem_fp[i] = {16'hC0DE, 16'(i)};
    end

    vecs[0] = '{1'b1, 1'b1, 16'h0010, 32'hDEADBEEF, 1'b0, 1'b0, 16'h0000, 32'h0,         1'b0, 32'hDEADBEEF, 1'b1};
    vecs[1] = '{1'b1, 1'b0, 16'h0010, 32'h0,        1'b0, 1'b0, 16'h0000, 32'h0,         1'b0, 32'hDEADBEEF, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 16'h0000, 32'h0,        1'b1, 1'b1, 16'hFFFF, 32'h12345678,  1'b1, 32'h12345678, 1'b1};
    vecs[3] = '{1'b0, 1'b0, 16'h0000, 32'h0,        1'b1, 1'b0, 16'hFFFF, 32'h0,         1'b1, 32'h12345678, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 16'h0000, 32'h0,        1'b0, 1'b0, 16'h0000, 32'h0,         1'b0, 32'hC0DE0000, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 16'h0010, 32'h0,        1'b1, 1'b0, 16'hFFFF, 32'h0,         1'b1, 32'h12345678, 1'b0};
    vecs[6] = '{1'b1, 1'b0, 16'h0010, 32'h0,        1'b1, 1'b0, 16'hFFFF, 32'h0,         1'b0, 32'hDEADBEEF, 1'b0};
    vecs[7] = '{1'b1, 1'b1, 16'h0100, 32'h11111111, 1'b1, 1'b1, 16'h0200, 32'h22222222,  1'b1, 32'h22222222, 1'b1};
    vecs[8] = '{1'b1, 1'b0, 16'h0200, 32'h0,        1'b0, 1'b0, 16'h0000, 32'h0,         1'b0, 32'h22222222, 1'b0};
    vecs[9] = '{1'b1, 1'b0, 16'h0100, 32'h0,        1'b0, 1'b0, 16'h0000, 32'h0,         1'b0, 32'hC0DE0100, 1'b0};

    repeat (2) @(negedge clk);
    chk("reset_busy",  {31'd0, busy},         32'd0);
    chk("reset_grant", {31'd0, grant},        32'd0);
    chk("reset_we",    {31'd0, ram_is_write}, 32'd0);
    chk("reset_acks",  {30'd0, p1_ack, p0_ack}, 32'd0);
    chk("reset_rdata", rdata, 32'd0);
    chk("reset_addr",  {16'd0, ram_address}, 32'd0);
    $display("reset: busy=%0d grant=%0d rdata=%h", busy, grant, rdata);
    reset_n = 1'b1;

    for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);
    chk("mem_0000_untouched", mem[16'h0000], 32'hC0DE0000);

    // Reset during ACCESS of a p1 write must cancel the RAM write at once.
    @(negedge clk);
    p1_req = 1; p1_we = 1; p1_addr = 16'h00FF; p1_wdata = 32'hBAD0BAD0;
    @(posedge clk);
    #1;
    chk("midwr_we_before", {31'd0, ram_is_write}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("midwr_we_after",   {31'd0, ram_is_write}, 32'd0);
    chk("midwr_busy_after", {31'd0, busy}, 32'd0);
    p1_req = 0; p1_we = 0;
    ack_cnt = 0;
    repeat (2) begin
      @(negedge clk);
      if (p0_ack || p1_ack) ack_cnt++;
    end
    reset_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (p0_ack || p1_ack) ack_cnt++;
    end
    chk("midwr_no_ack", 32'(ack_cnt), 32'd0);
    chk("midwr_mem_00ff", mem[16'h00FF], 32'hC0DE00FF);
    $display("reset mid-write: acks=%0d mem[00FF]=%h", ack_cnt, mem[16'h00FF]);

    // Continuous contention on both DUTs: RR alternates starting at port 0; fixed priority serves only port 0.
    p0_req = 1; p0_we = 0; p0_addr = 16'h0010;
    p1_req = 1; p1_we = 0; p1_addr = 16'hFFFF;
    f0_req = 1; f1_req = 1;
    ack_cnt = 0; last_ack_c = 0; fp0_cnt = 0; fp1_cnt = 0;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      if (p0_ack && p1_ack) chk("rr_both_acks", 32'd1, 32'd0);
      if (fp0_ack && fp1_ack) chk("fp_both_acks", 32'd1, 32'd0);
      if (p0_ack || p1_ack) begin
        exp_g = (ack_cnt % 2 == 1) ? 32'd1 : 32'd0;
        exp_d = (ack_cnt % 2 == 1) ? 32'h12345678 : 32'hDEADBEEF;
        chk("rr_grant", {31'd0, grant}, exp_g);
        chk("rr_ack_port", {31'd0, p1_ack}, exp_g);
        chk("rr_rdata", rdata, exp_d);
        chk("rr_spacing", 32'(c - last_ack_c), (ack_cnt == 0) ? 32'd2 : 32'd3);
        $display("rr ack %0d: cycle=%0d grant=%0d rdata=%h", ack_cnt, c, grant, rdata);
        last_ack_c = c;
        ack_cnt++;
      end
      if (fp0_ack) fp0_cnt++;
      if (fp1_ack) fp1_cnt++;
      if (c == 8) begin
        f0_req = 0; f1_req = 0;
      end
    end
    p0_req = 0; p1_req = 0;
    chk("rr_ack_count", 32'(ack_cnt), 32'd4);
    chk("fp_p0_count", 32'(fp0_cnt), 32'd3);
    chk("fp_p1_count", 32'(fp1_cnt), 32'd0);
    $display("fixed priority: p0_acks=%0d p1_acks=%0d", fp0_cnt, fp1_cnt);

    repeat (3) @(negedge clk);
    chk("final_idle", {31'd0, busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
